// File: rtl/machine_timer.sv
// Purpose: memory-mapped RISC-V machine timer (mtime/mtimecmp) driving a level timer_intr.
// Latency: ack and rdata one cycle after req; timer_intr registered from post-update compare.
// Backpressure: none, a request may be issued every cycle. Optional prescaler: MACHINE_TIMER_PRESCALE_EN.
module machine_timer #(
  parameter int          ADDR_W    = 5,
  parameter logic [63:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              timer_intr
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] IDX_TIME_LO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_TIME_HI = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_CMP_LO  = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_CMP_HI  = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_CTRL    = IDX_W'(4);
`ifdef MACHINE_TIMER_PRESCALE_EN
  localparam logic [IDX_W-1:0] IDX_PRE     = IDX_W'(5);
`endif

  logic [IDX_W-1:0] idx;
  logic             unused_addr_lsb;
  logic [63:0]      mtime, mtime_nxt;
  logic [63:0]      mtimecmp, cmp_nxt;
  logic             enable;
  logic             tick;
  logic             wr;
  logic [31:0]      rd_val;

  // Byte address bits [1:0] carry no information in a word-aligned map.
  assign idx             = addr[ADDR_W-1:2];
  assign unused_addr_lsb = ^addr[1:0];
  assign wr              = req & we;

`ifdef MACHINE_TIMER_PRESCALE_EN
  logic [15:0] prescale;
  logic [15:0] pcnt;

  // One tick per (prescale+1) cycles; prescale=0 ticks every cycle.
  assign tick = (pcnt == prescale);

  // Prescale register and its divider; a write restarts the divider.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prescale <= 16'h0;
      pcnt     <= 16'h0;
    end else if (wr && idx == IDX_PRE) begin
      prescale <= wdata[15:0];
      pcnt     <= 16'h0;
    end else if (enable) begin
      pcnt <= tick ? 16'h0 : pcnt + 16'h1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Next-state of counter and compare: a bus write to a half beats the increment and
  // leaves the other half untouched, so no carry crosses in a write cycle.
  always_comb begin
    mtime_nxt = mtime;
    cmp_nxt   = mtimecmp;
    if (wr && idx == IDX_TIME_LO)      mtime_nxt = {mtime[63:32], wdata};
    else if (wr && idx == IDX_TIME_HI) mtime_nxt = {wdata, mtime[31:0]};
    else if (enable && tick)           mtime_nxt = mtime + 64'd1;
    if (wr && idx == IDX_CMP_LO)       cmp_nxt = {mtimecmp[63:32], wdata};
    else if (wr && idx == IDX_CMP_HI)  cmp_nxt = {wdata, mtimecmp[31:0]};
  end

  // Read mux over the current (pre-update) register values.
  always_comb begin
    rd_val = 32'h0;
    case (idx)
      IDX_TIME_LO: rd_val = mtime[31:0];
      IDX_TIME_HI: rd_val = mtime[63:32];
      IDX_CMP_LO:  rd_val = mtimecmp[31:0];
      IDX_CMP_HI:  rd_val = mtimecmp[63:32];
      IDX_CTRL:    rd_val = {31'h0, enable};
`ifdef MACHINE_TIMER_PRESCALE_EN
      IDX_PRE:     rd_val = {16'h0, prescale};
`endif
      default:     rd_val = 32'h0;
    endcase
  end

  // Timer state and interrupt; the compare sees this cycle's updated values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtime      <= 64'h0;
      mtimecmp   <= RESET_CMP;
      enable     <= 1'b1;
      timer_intr <= 1'b0;
    end else begin
      mtime      <= mtime_nxt;
      mtimecmp   <= cmp_nxt;
      timer_intr <= (mtime_nxt >= cmp_nxt);
      if (wr && idx == IDX_CTRL) enable <= wdata[0];
    end
  end

  // Bus response: ack every accepted request; rdata holds until the next ack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack   <= 1'b0;
      rdata <= 32'h0;
    end else begin
      ack <= req;
      if (req) rdata <= we ? 32'h0 : rd_val;
    end
  end

endmodule
